// File: rtl/collect_two.sv
// Reassembles four 2-bit symbols (LSB pair first) into a byte with a one-deep holding register.
// Optional symbol-gap watchdog enabled by defining COLLECT_TWO_TIMEOUT_EN.
module collect_two #(
    parameter int SYM_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       byte_done,
    output logic       overrun,
    output logic       timeout_err,
    output logic [1:0] fsm_state
);

    // Handshake: a byte moves to the consumer on any rising edge where
    // data_valid=1 and data_ready=1; data_out is stable while data_valid=1.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2,
        G3   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] part, part_nxt;
    logic       commit;
    logic [7:0] commit_byte;
    logic       to_fire;
    logic       hold_free;

    if (SYM_TIMEOUT < 2 || SYM_TIMEOUT > 1023) begin : g_bad_param
        $error("collect_two: SYM_TIMEOUT must be in 2..1023");
    end

    assign fsm_state   = state;
    assign commit_byte = {sym_in, part};
    // Holding register may take a new byte if empty or being drained this cycle.
    assign hold_free   = !data_valid || data_ready;

    always_comb begin
        state_nxt = state;
        part_nxt  = part;
        commit    = 1'b0;
        if (resync) begin
            state_nxt = IDLE;
            part_nxt  = '0;
        end else if (sym_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = G1;
                    part_nxt  = {4'b0, sym_in};
                end
                G1: begin
                    state_nxt = G2;
                    part_nxt  = {2'b0, sym_in, part[1:0]};
                end
                G2: begin
                    state_nxt = G3;
                    part_nxt  = {sym_in, part[3:0]};
                end
                default: begin
                    state_nxt = IDLE;
                    part_nxt  = '0;
                    commit    = 1'b1;
                end
            endcase
        end else if (to_fire) begin
            state_nxt = IDLE;
            part_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            part  <= '0;
        end else begin
            state <= state_nxt;
            part  <= part_nxt;
        end
    end

`ifdef COLLECT_TWO_TIMEOUT_EN
    logic [9:0] idle_cnt;

    // resync takes priority, so a coincident expiry never reports an error.
    assign to_fire = (state != IDLE) && !sym_valid && !resync &&
                     (idle_cnt == 10'(SYM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_fire;
            if (state_nxt == IDLE || sym_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 10'd1;
            end
        end
    end
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            byte_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            byte_done <= commit;
            overrun   <= commit && !hold_free;
            if (commit && hold_free) begin
                data_out   <= commit_byte;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_collect_two.sv
// Bench for collect_two: a symbol-count/arithmetic model checked every cycle,
// plus directed sequences with hand-computed byte values.
module tb_collect_two;

    localparam int SYM_TIMEOUT = 256;

    logic       clk;
    logic       rst_n;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       resync;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       byte_done;
    logic       overrun;
    logic       timeout_err;
    logic [1:0] fsm_state;

    int tests;
    int fails;
    bit chk_en;

    collect_two #(.SYM_TIMEOUT(SYM_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .resync     (resync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .byte_done  (byte_done),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: symbols gathered so far, their arithmetic value, gap length
    int         m_n;
    int         m_part;
    int         m_idle;
    bit         m_dv;
    logic [7:0] m_dout;
    bit         m_bd;
    bit         m_ov;
    bit         m_to;
    bit         m_done;
    int         m_byte;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_part = 0; m_idle = 0;
            m_dv = 0; m_dout = 8'h00;
            m_bd = 0; m_ov = 0; m_to = 0;
        end else begin
            m_done = 0;
            m_byte = 0;
            m_bd = 0; m_ov = 0; m_to = 0;
            if (resync) begin
                m_n = 0; m_part = 0; m_idle = 0;
            end else if (sym_valid) begin
                m_part = m_part + (int'(sym_in) << (2 * m_n));
                m_n = m_n + 1;
                m_idle = 0;
                if (m_n == 4) begin
                    m_done = 1;
                    m_byte = m_part;
                    m_n = 0;
                    m_part = 0;
                end
            end else if (m_n > 0) begin
`ifdef COLLECT_TWO_TIMEOUT_EN
                if (m_idle == SYM_TIMEOUT - 1) begin
                    m_to = 1; m_n = 0; m_part = 0; m_idle = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
`endif
            end
            if (m_done) begin
                m_bd = 1;
                if (!m_dv || data_ready) begin
                    m_dout = 8'(m_byte);
                    m_dv = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (m_dv && data_ready) begin
                m_dv = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", {7'b0, data_valid}, {7'b0, m_dv});
            chk("data_out", data_out, m_dout);
            chk("byte_done", {7'b0, byte_done}, {7'b0, m_bd});
            chk("overrun", {7'b0, overrun}, {7'b0, m_ov});
            chk("timeout_err", {7'b0, timeout_err}, {7'b0, m_to});
            chk("fsm_state", {6'b0, fsm_state}, 8'(m_n));
        end
    end

    // driver tasks: called at a falling edge, return at a falling edge
    task automatic sym(input logic [1:0] s);
        sym_in = s;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        sym_in = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resync_with_sym(input logic [1:0] s);
        resync = 1'b1;
        sym_valid = 1'b1;
        sym_in = s;
        @(negedge clk);
        resync = 1'b0;
        sym_valid = 1'b0;
        sym_in = 2'b00;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk_en = 0;
        rst_n = 1'b0;
        sym_in = 2'b00;
        sym_valid = 1'b0;
        resync = 1'b0;
        data_ready = 1'b1;
        @(negedge clk);
        chk_en = 1;
        idle(2);
        chk("rst data_out", data_out, 8'h00);
        chk("rst data_valid", {7'b0, data_valid}, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // single byte, consumer ready
        sym(2'b01); sym(2'b10); sym(2'b11); sym(2'b00);
        chk("b39 data_out", data_out, 8'h39);
        chk("b39 byte_done", {7'b0, byte_done}, 8'h01);
        chk("b39 data_valid", {7'b0, data_valid}, 8'h01);
        idle(1);
        chk("b39 dv drop", {7'b0, data_valid}, 8'h00);

        // overrun: consumer stalled
        data_ready = 1'b0;
        sym(2'b01); sym(2'b10); sym(2'b11); sym(2'b00);
        sym(2'b11); sym(2'b11); sym(2'b11); sym(2'b11);
        chk("ovr pulse", {7'b0, overrun}, 8'h01);
        chk("ovr data_out", data_out, 8'h39);
        idle(1);
        chk("ovr once", {7'b0, overrun}, 8'h00);
        data_ready = 1'b1;
        idle(1);
        chk("ovr drained", {7'b0, data_valid}, 8'h00);

        // accept and reload in the same cycle
        data_ready = 1'b0;
        sym(2'b00); sym(2'b01); sym(2'b10); sym(2'b11);
        chk("e4 data_out", data_out, 8'hE4);
        sym(2'b01); sym(2'b01); sym(2'b01);
        data_ready = 1'b1;
        sym(2'b10);
        chk("reload data_out", data_out, 8'h95);
        chk("reload dv", {7'b0, data_valid}, 8'h01);
        chk("reload no ovr", {7'b0, overrun}, 8'h00);
        idle(2);

`ifdef COLLECT_TWO_TIMEOUT_EN
        // gap expiry drops the partial byte
        sym(2'b11); sym(2'b01);
        idle(SYM_TIMEOUT - 1);
        chk("to early", {7'b0, timeout_err}, 8'h00);
        idle(1);
        chk("to pulse", {7'b0, timeout_err}, 8'h01);
        sym(2'b00); sym(2'b00); sym(2'b00); sym(2'b10);
        chk("to next byte", data_out, 8'h80);
        idle(2);
        // symbol arriving on the last allowed cycle is kept
        sym(2'b10); sym(2'b10);
        idle(SYM_TIMEOUT - 1);
        sym(2'b01);
        chk("edge no to", {7'b0, timeout_err}, 8'h00);
        idle(1);
        chk("edge no to2", {7'b0, timeout_err}, 8'h00);
        sym(2'b00);
        chk("edge byte", data_out, 8'h1A);
        idle(2);
`else
        // without the watchdog a partial byte waits indefinitely
        sym(2'b11); sym(2'b01);
        idle(300);
        chk("no to", {7'b0, timeout_err}, 8'h00);
        sym(2'b00); sym(2'b10);
        chk("held byte", data_out, 8'h87);
        idle(2);
`endif

        // resync wins over a coincident strobe
        sym(2'b01); sym(2'b01); sym(2'b01);
        resync_with_sym(2'b11);
        chk("resync no bd", {7'b0, byte_done}, 8'h00);
        sym(2'b01); sym(2'b00); sym(2'b00); sym(2'b00);
        chk("resync byte", data_out, 8'h01);
        chk("resync bd", {7'b0, byte_done}, 8'h01);
        idle(2);

        // reset mid-byte with a byte pending
        data_ready = 1'b0;
        sym(2'b11); sym(2'b11); sym(2'b11); sym(2'b11);
        chk("ff data_out", data_out, 8'hFF);
        sym(2'b01); sym(2'b01);
        rst_n = 1'b0;
        idle(2);
        chk("mid rst dout", data_out, 8'h00);
        chk("mid rst dv", {7'b0, data_valid}, 8'h00);
        rst_n = 1'b1;
        idle(1);
        chk("rst exit bd", {7'b0, byte_done}, 8'h00);
        data_ready = 1'b1;
        sym(2'b10); sym(2'b10); sym(2'b10); sym(2'b10);
        chk("aa byte", data_out, 8'hAA);
        idle(3);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/collect_two.md
COLLECT_TWO -- requirements
Module: collect_two

Interface
REQ-001: Parameter SYM_TIMEOUT, default 256, sets the clocks allowed between accepted symbols before a partial byte is dropped (legal 2..1023).
REQ-002: clk  input  1  sole clock; all logic on rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: sym_in  input  2  demodulated 2-bit symbol; sym_in[0] is the lower bit of the pair.
REQ-005: sym_valid  input  1  one-cycle strobe; sym_in is valid in this cycle.
REQ-006: resync  input  1  frame realign; discards any partial byte.
REQ-007: data_out  output  8  assembled byte, held stable while data_valid=1.
REQ-008: data_valid  output  1  byte available; held until accepted.
REQ-009: data_ready  input  1  consumer accept; transfer occurs when data_valid=1 and data_ready=1.
REQ-010: byte_done  output  1  one-cycle pulse when the 4th symbol of a byte is accepted.
REQ-011: overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-012: timeout_err  output  1  one-cycle pulse when a partial byte is dropped on timeout.

Function
REQ-013: The block SHALL reassemble 4 consecutive symbols into one byte, LSB pair first: symbol k (k=0..3) goes to bits [2k+1:2k].
REQ-014: The FSM SHALL have states IDLE, G1, G2 and G3, holding 0, 1, 2 and 3 collected symbols respectively.
REQ-015: On sym_valid, the FSM SHALL step IDLE->G1->G2->G3; sym_valid in G3 SHALL commit the byte and return to IDLE.
REQ-016: Commit SHALL pulse byte_done in the cycle after the 4th sym_valid; data_valid SHALL rise in that same cycle if the holding register was free.
REQ-017: The holding register SHALL be free when data_valid=0, or when data_valid=1 and data_ready=1 in the commit cycle (accept and reload in the same cycle).
REQ-018: If the holding register is not free at commit, the new byte SHALL be dropped, data_out SHALL keep the old byte, and overrun SHALL pulse in the cycle after the 4th sym_valid.
REQ-019: data_valid SHALL fall in the cycle after data_ready=1 unless the same cycle reloads it.
REQ-020: In states other than IDLE, a 10-bit idle counter SHALL increment each cycle without sym_valid and SHALL clear on each accepted symbol and on entry to IDLE.
REQ-021: When the counter equals SYM_TIMEOUT-1 and sym_valid=0, the FSM SHALL go to IDLE, the partial byte SHALL be discarded, and timeout_err SHALL pulse in the next cycle.
REQ-022: If sym_valid=1 in the timeout cycle, the symbol SHALL be accepted and no timeout SHALL occur.
REQ-023: resync=1 SHALL force IDLE, clear the counter and partial byte, and ignore a coincident sym_valid.
REQ-024: resync SHALL NOT affect data_out or data_valid, and SHALL NOT generate timeout_err.
REQ-025: In IDLE the counter SHALL stay at 0, so no timeout is possible.

Reset
REQ-026: While rst_n=0 at a clock edge, the block SHALL set FSM=IDLE, counter=0, partial byte=0, data_out=8'h00 and data_valid=0.
REQ-027: While rst_n=0 at a clock edge, byte_done, overrun and timeout_err SHALL be 0.
REQ-028: Reset asserted mid-byte or with data_valid=1 SHALL discard all contents; no pulse SHALL be generated on reset exit.

Configuration
REQ-029: Macro COLLECT_TWO_TIMEOUT_EN SHALL control the timeout watchdog.
REQ-030: With COLLECT_TWO_TIMEOUT_EN defined, the counter and timeout behaviour of REQ-020..022 SHALL be present.
REQ-031: Without COLLECT_TWO_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied 0, and a partial byte SHALL be held indefinitely.

Verification
REQ-032: Symbols 01,10,11,00 with data_ready=1 -> data_out=8'h39 and byte_done=1 one cycle after the 4th strobe; data_valid=1 for one cycle.
REQ-033: Two bytes (8'h39, then 11,11,11,11) with data_ready=0 -> data_out stays 8'h39 and overrun pulses once after the 8th symbol.
REQ-034: With the macro defined, SYM_TIMEOUT=256 and 2 symbols sent followed by 256 idle clocks -> timeout_err pulse; a following 4 symbols 00,00,00,10 -> data_out=8'h80.
REQ-035: With the macro defined, a symbol arriving exactly at counter=255 -> accepted, no timeout_err.
REQ-036: 3 symbols, then resync (coincident with a 4th strobe), then 01,00,00,00 -> single byte 8'h01, no error pulses.
REQ-037: rst_n=0 asserted after 2 symbols with data_valid=1 -> all outputs 0; the next 4 symbols 10,10,10,10 -> 8'hAA.
